seq_magnitude_comparator: RTL
=============================

SEQ_MAGNITUDE_COMPARATOR -- requirements
Module: seq_magnitude_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits.
REQ-002 SHALL have parameter DIGIT, default 4: bits compared per cycle; WIDTH SHALL be an integer multiple of DIGIT (elaboration error otherwise); NDIG = WIDTH/DIGIT.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request a comparison; accepted only when busy=0.
REQ-006 SHALL have ports a and b, input, WIDTH bits each: operands, sampled on the accepting edge.
REQ-007 SHALL have port signed_mode, input, 1 bit: 1 = two's-complement compare, 0 = unsigned; sampled on the accepting edge.
REQ-008 SHALL have ports lin, ein and gin, input, 1 bit each: cascade less/equal/greater from the higher-order stage; sampled on the accepting edge.
REQ-009 SHALL have port busy, output, 1 bit: comparison in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-011 SHALL have ports lout, eout and gout, output, 1 bit each: registered one-hot result, held until the next done.

Function
REQ-012 SHALL implement FSM IDLE/CMP: IDLE to CMP on start; CMP to IDLE on decision.
REQ-013 On the accepting edge: latch a, b, signed_mode and cascade; digit counter cnt to 0; busy to 1.
REQ-014 Cascade decode at acceptance: ein=1 means compare operands; else gin=1 means forced greater; else forced less (lin is implied, no error flag).
REQ-015 Forced cascade result SHALL decide on the first CMP edge without examining operands.
REQ-016 In CMP, each cycle SHALL compare digit cnt, MSB-first (cnt=0 is bits WIDTH-1..WIDTH-DIGIT).
REQ-017 Signed mode SHALL invert bit WIDTH-1 of both latched operands before comparison; no other arithmetic.
REQ-018 Decision occurs at the edge ending a CMP cycle whose digit is unequal, or whose cnt=NDIG-1 (equal result); otherwise cnt increments.
REQ-019 Early termination: for deciding digit index k, done SHALL be high in the cycle after edge k+1 counted from the accepting edge (max NDIG cycles latency, min 1).
REQ-020 On decision: lout/eout/gout registered one-hot, done=1 for exactly one cycle, busy=0, state IDLE.
REQ-021 start while busy=1 SHALL be ignored with no effect on the operation in flight.
REQ-022 start in the done cycle SHALL be accepted (back-to-back); results hold until that operation's own done.
REQ-023 Operand and mode inputs SHALL be ignored outside the accepting edge.

Reset
REQ-024 rstn low SHALL asynchronously force state IDLE, cnt=0, busy=0, done=0, lout=0, eout=0, gout=0.
REQ-025 Reset mid-operation SHALL abort with no done pulse; first start after rstn deassertion behaves as from cold.

Structure
REQ-026 Shared package cmp_pkg SHALL hold the FSM state enum and the result encoding (LT/EQ/GT).
REQ-027 The per-cycle digit compare SHALL be a combinational sub-module digit_comparator (DIGIT-bit a/b in, lt/eq/gt out), instantiated once.
REQ-028 Operand registers SHALL shift by DIGIT per cycle or be indexed by cnt; counter width SHALL be clog2(NDIG), minimum 1.

Verification (WIDTH=32, DIGIT=4)
REQ-029 Test: a=b=0x12345678, ein=1, start -> done 8 cycles after accept, eout=1, busy high for 8 cycles.
REQ-030 Test: a=0x90000000, b=0x10000000, ein=1 -> unsigned: gout=1, done 1 cycle after accept; repeated signed_mode=1: lout=1, 1 cycle.
REQ-031 Test: a=0x12345670, b=0x12345671, ein=1 -> lout=1 at 8 cycles; swap operands -> gout=1.
REQ-032 Test: lin=1, ein=0, a=0xFFFFFFFF, b=0 -> lout=1, done 1 cycle after accept; gin=1, ein=0 -> gout=1.
REQ-033 Test: start pulsed mid-operation -> ignored, first result unaffected; start in the done cycle -> second result correct; rstn low at cycle 3 of 8 -> all outputs 0 immediately, no done.
REQ-034 Test: random a/b/signed_mode for 10000 operations vs a reference model; check latency and one-hot result.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states,
// cascade decode and the one-hot {less, equal, greater} result encoding.
package cmp_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_CMP
    } state_t;

    // Result bits map directly onto {lout, eout, gout}
    typedef enum logic [2:0] {
        RES_NONE = 3'b000,
        RES_LT   = 3'b100,
        RES_EQ   = 3'b010,
        RES_GT   = 3'b001
    } res_t;

    // How the higher-order stage constrains this comparison
    typedef enum logic [1:0] {
        CASC_CMP,
        CASC_GT,
        CASC_LT
    } casc_t;

    // ein wins, then gin; anything else is treated as less (lin implied)
    function automatic casc_t casc_decode(input logic ein, input logic gin);
        if (ein)      return CASC_CMP;
        else if (gin) return CASC_GT;
        else          return CASC_LT;
    endfunction

endpackage

// File: rtl/digit_comparator.sv
// Combinational compare of one DIGIT-wide slice of the operands.
module digit_comparator #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    // Unsigned relation of the two digits
    always_comb begin
        lt = (a < b);
        eq = (a == b);
        gt = (a > b);
    end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Digit-serial magnitude comparator: examines DIGIT bits per cycle from the
// MSB end and stops at the first unequal digit, with cascade inputs so that
// several stages can be chained.
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    input  logic             lin,
    input  logic             ein,
    input  logic             gin,
    output logic             busy,
    output logic             done,
    output logic             lout,
    output logic             eout,
    output logic             gout
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    generate
        if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("seq_magnitude_comparator: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    casc_t            casc_q, casc_d;
    res_t             res_q, res_d;
    logic             done_q, done_d;

    logic             dig_lt, dig_eq, dig_gt;
    logic [WIDTH-1:0] sign_flip;

    // lin carries no information beyond !ein && !gin
    logic             unused_lin;
    assign unused_lin = lin;

    // Operands shift left each cycle, so the digit under test is always the top one
    digit_comparator #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a  (a_q[WIDTH-1 -: DIGIT]),
        .b  (b_q[WIDTH-1 -: DIGIT]),
        .lt (dig_lt),
        .eq (dig_eq),
        .gt (dig_gt)
    );

    // Next-state, operand shift and result decision
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        casc_d    = casc_q;
        res_d     = res_q;
        done_d    = 1'b0;
        // Flipping the sign bit maps two's-complement order onto unsigned order
        sign_flip = signed_mode ? (WIDTH'(1) << (WIDTH - 1)) : '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CMP;
                    cnt_d   = '0;
                    a_d     = a ^ sign_flip;
                    b_d     = b ^ sign_flip;
                    casc_d  = casc_decode(ein, gin);
                end
            end
            ST_CMP: begin
                if (casc_q == CASC_GT) begin
                    res_d   = RES_GT;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (casc_q == CASC_LT) begin
                    res_d   = RES_LT;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (!dig_eq) begin
                    res_d   = dig_lt ? RES_LT : (dig_gt ? RES_GT : RES_NONE);
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == LAST_DIG) begin
                    res_d   = RES_EQ;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    a_d   = a_q << DIGIT;
                    b_d   = b_q << DIGIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and result registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            casc_q  <= CASC_CMP;
            res_q   <= RES_NONE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            casc_q  <= casc_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    assign busy               = (state_q == ST_CMP);
    assign done               = done_q;
    assign {lout, eout, gout} = res_q;

endmodule
